// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Multicycle load/store sequencer between instruction decode, a data memory
// and the register file. It accepts one decoded memory request at a time over
// a valid/ready handshake:
//   - STORE  : one cycle driving the memory write port.
//   - LOAD   : drives the address for MEM_LAT cycles, samples the read data,
//              then spends one cycle writing it back to the register file.
//   - LOADB  : as LOAD, but writes back bits [7:0] sign-extended to DATA_W.
//   - illegal: no memory or register-file activity; err pulses for one cycle.
// Completed loads and stores are counted in saturating counters.
//
// Parameters
//   DATA_W   data word width (memory and register file)
//   ADDR_W   memory address width
//   REG_AW   register file address width
//   MEM_LAT  memory read latency in cycles, legal range 1..4
//   CNT_W    width of the load/store counters
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   req_valid/req_ready         request handshake (ready only while idle)
//   req_op                      00 LOAD, 01 STORE, 10 LOADB, 11 illegal
//   req_addr/req_rd/req_wdata   request address, load destination, store data
//   mem_addr/mem_we/mem_wdata   memory port (outputs)
//   mem_rdata                   memory read data (input)
//   rf_we/rf_waddr/rf_wdata     register file write port
//   done                        one-cycle pulse on store or load writeback
//   err                         one-cycle pulse after an illegal op is accepted
//   load_cnt/store_cnt          saturating completion counters
//
// All outputs are registers or decodes of the state register, so there is no
// combinational path from the request inputs to any output.
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int REG_AW  = 4,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [REG_AW-1:0] req_rd,
    input  logic [DATA_W-1:0] req_wdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,

    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  load_cnt,
    output logic [CNT_W-1:0]  store_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        STORE,
        READ,
        WB
    } state_t;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_LOADB = 2'b10;

    // Two bits cover the full legal latency range (MEM_LAT-1 is at most 3).
    localparam logic [1:0] LAT_INIT = 2'(MEM_LAT - 1);

    state_t     state;
    logic [1:0] lat_cnt;
    logic       is_byte;   // captured "this load is LOADB"

    // Handshake and port strobes are pure decodes of the state register.
    assign req_ready = (state == IDLE);
    assign mem_we    = (state == STORE);
    assign rf_we     = (state == WB);
    assign done      = (state == STORE) || (state == WB);

    // NOTE: every register here is updated with non-blocking assignments so
    // that all of them see the pre-edge values of each other, exactly like
    // the flip-flops they describe; blocking assignments would make the
    // result depend on statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            is_byte   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            err       <= 1'b0;
            load_cnt  <= '0;
            store_cnt <= '0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        // Capture the request; mem_addr/mem_wdata/rf_waddr are
                        // driven straight from these registers.
                        mem_addr  <= req_addr;
                        mem_wdata <= req_wdata;
                        rf_waddr  <= req_rd;
                        is_byte   <= (req_op == OP_LOADB);
                        case (req_op)
                            OP_STORE: state <= STORE;
                            OP_LOAD, OP_LOADB: begin
                                state   <= READ;
                                lat_cnt <= LAT_INIT;
                            end
                            // Illegal op: stay idle so the next request can be
                            // taken immediately; only flag the error.
                            default: err <= 1'b1;
                        endcase
                    end
                end

                STORE: begin
                    if (store_cnt != '1) store_cnt <= store_cnt + CNT_W'(1);
                    state <= IDLE;
                end

                READ: begin
                    if (lat_cnt == 2'd0) begin
                        // Last latency cycle: the memory data is valid now.
                        rf_wdata <= is_byte
                                  ? {{(DATA_W-8){mem_rdata[7]}}, mem_rdata[7:0]}
                                  : mem_rdata;
                        state    <= WB;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end

                WB: begin
                    if (load_cnt != '1) load_cnt <= load_cnt + CNT_W'(1);
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
